uart_loader: RTL and testbench
==============================

# uart_loader

Program-load controller between the `uart_rx` byte receiver and the CPU instruction memory. It parses a framed byte stream from the host and packs the bytes into 32-bit words. It writes those words to consecutive instruction-memory addresses and holds the CPU in reset while a load is in progress. It raises a done pulse or a sticky error when the frame ends.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; the maximum frame is 2^ADDR_WIDTH words.
- `TIMEOUT_CLKS`, default 1000000: idle clocks allowed between bytes inside a frame before the frame is aborted.
- `i_Clock` input 1: single clock, shared with `uart_rx`.
- `i_Reset` input 1: synchronous, active-high reset.
- `i_Rx_DV` input 1: byte-valid strobe from `uart_rx`, one cycle wide.
- `i_Rx_Byte` input 8: received byte, valid when `i_Rx_DV`=1.
- `o_Mem_WE` output 1: instruction-memory write enable, one-cycle pulse.
- `o_Mem_Addr` output ADDR_WIDTH: word address for the write.
- `o_Mem_WData` output 32: word to write.
- `o_Cpu_Hold` output 1: holds the CPU pipeline in reset while high.
- `o_Done` output 1: one-cycle pulse when a frame loads successfully.
- `o_Error` output 1: sticky frame error.

## Operation
- Frame format: sync byte 0xA5, then LEN_LO and LEN_HI (16-bit word count N, little-endian), then 4·N data bytes, then a checksum byte if enabled (see Configuration).
- Data words are little-endian: the first byte of each group of four goes to bits [7:0].
- States and transitions:
  - IDLE → LEN_LO on byte 0xA5. Any other byte is ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI → DATA if 1 ≤ N ≤ 2^ADDR_WIDTH. Otherwise LEN_HI → ERROR.
  - DATA → CSUM after the 4·N-th byte when the checksum is enabled. Otherwise DATA → DONE.
  - CSUM → DONE if the checksum matches. Otherwise CSUM → ERROR.
  - DONE → IDLE after one cycle.
  - ERROR → LEN_LO on byte 0xA5, which starts a new frame and clears `o_Error`. Other bytes keep the block in ERROR.
  - Any state except IDLE, DONE and ERROR goes to ERROR on timeout.
- Byte lane counter: 2 bits, wraps 3→0. Address counter: ADDR_WIDTH+1 bits so that N = 2^ADDR_WIDTH can be detected. Both counters clear when LEN_LO is entered.
- Remaining-word counter: 16 bits, loaded with N, decremented on each word write. DATA exits when it reaches 0.
- `o_Cpu_Hold` is 1 in LEN_LO, LEN_HI, DATA, CSUM and ERROR, and 0 in IDLE and DONE.
- Words are written as they complete. An error does not roll back earlier writes; the CPU stays held until a good frame arrives or reset.
- Timeout counter: clears on every `i_Rx_DV` and saturates. It is active only in LEN_LO, LEN_HI, DATA and CSUM, and triggers ERROR when it reaches TIMEOUT_CLKS-1.
- A byte that arrives in the same cycle as the timeout expiry is dropped; the timeout wins.

## Timing
- Reset values: `o_Mem_WE`=0, `o_Mem_Addr`=0, `o_Mem_WData`=0, `o_Cpu_Hold`=0, `o_Done`=0, `o_Error`=0. All counters are 0 and the state is IDLE.
- Reset mid-frame takes effect at the next edge: any pending write is squashed and the hold is released.
- Word write latency: if the 4th byte of a word has `i_Rx_DV` at edge t, then `o_Mem_WE`=1 in the cycle after edge t+1. Address and data are stable in that same cycle and `o_Mem_WE` is high for exactly one cycle.
- State changes happen at the edge that samples `i_Rx_DV`. `o_Cpu_Hold` rises in the cycle after the 0xA5 byte.
- DONE timing: `o_Done` is high for exactly one cycle. It follows the last data byte's write (checksum disabled) or the checksum byte (checksum enabled), with a one-cycle latency. `o_Cpu_Hold` falls in the same cycle that `o_Done` rises.
- `i_Rx_DV` during DONE is ignored; `uart_rx` spacing guarantees no data loss.
- `o_Error` rises one cycle after the failing byte or the timeout and stays high until 0xA5 or reset.

## Configuration
- `UART_LOADER_CSUM_EN` defined:
  - CSUM state is present.
  - The checksum is the XOR of all 4·N data bytes, accumulated in DATA.
  - A mismatch goes to ERROR and `o_Done` does not pulse.
- Not defined:
  - No CSUM state and no accumulator.
  - DATA goes directly to DONE after the final word write.
  - The host sends no checksum byte.

## Test plan
- Reset, then frame A5 02 00 | 13 00 00 00 | 93 00 10 00 (+ checksum 0x90 if enabled) → writes addr0=0x00000013 and addr1=0x00100093, one `o_Done` pulse, `o_Cpu_Hold` high from after A5 until Done.
- Bytes 00 FF 3C in IDLE → no writes, hold stays 0. A following valid frame loads normally.
- N=0 (A5 00 00) → ERROR and hold=1. N=2^ADDR_WIDTH+1 → ERROR with no writes. N=2^ADDR_WIDTH → all addresses written, Done pulses.
- Checksum enabled, wrong checksum 0x00 for the first frame → both words written, `o_Error`=1, no Done. Then a correct frame → `o_Error` clears and Done pulses.
- Stop the frame after 5 of 8 data bytes and wait TIMEOUT_CLKS (bench uses 100) → ERROR, one write only. A5 restarts the load.
- Assert `i_Reset` in the cycle after a word's 4th byte → no `o_Mem_WE` pulse, all outputs at reset values.

Source files
------------

// File: rtl/uart_loader.sv
// Frame parser that packs host bytes into 32-bit words and writes them to instruction memory.
// Optional checksum byte support is enabled by defining UART_LOADER_CSUM_EN.
module uart_loader #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Mem_WE,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [31:0]           o_Mem_WData,
  output logic                  o_Cpu_Hold,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef UART_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [TMO_W-1:0]      tmo_q;
  logic [1:0]            lane_q;
  logic [CNT_W-1:0]      addr_q;
  logic [15:0]           rem_q;
  logic [7:0]            len_lo_q;
  logic [23:0]           word_q;
  logic                  wr_pend_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        tmo_active, tmo_hit, byte_ok, hold_c;
  logic        len_valid, last_word;
  logic [15:0] n_words;
  logic        clr_cnt, len_ld, byte_take, word_done;

`ifdef UART_LOADER_CSUM_EN
  assign tmo_active = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
`else
  assign tmo_active = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA};
`endif

  // Timeout expiry wins over a byte arriving in the same cycle.
  assign tmo_hit   = tmo_active && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));
  assign byte_ok   = i_Rx_DV && !tmo_hit;
  assign hold_c    = tmo_active || (state_q == S_ERROR);
  assign n_words   = {i_Rx_Byte, len_lo_q};
  assign len_valid = (n_words != 16'd0) && (17'(n_words) <= 17'(MAX_WORDS));
  assign last_word = (rem_q == 16'd1) || (addr_q == CNT_W'(MAX_WORDS - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt   = 1'b0;
    len_ld    = 1'b0;
    byte_take = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_LEN_LO;
          clr_cnt = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (byte_ok) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (byte_ok) begin
          state_d = len_valid ? S_DATA : S_ERROR;
          len_ld  = len_valid;
        end
      end
      S_DATA: begin
        if (byte_ok) begin
          byte_take = 1'b1;
          if (lane_q == 2'd3) begin
            word_done = 1'b1;
            if (last_word) begin
`ifdef UART_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef UART_LOADER_CSUM_EN
      S_CSUM: begin
        if (byte_ok) state_d = (i_Rx_Byte == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_ERROR;
  end

  // Datapath: counters, word assembly, two-stage write pipeline and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tmo_q       <= '0;
      lane_q      <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      len_lo_q    <= '0;
      word_q      <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
      o_Mem_WE    <= 1'b0;
      o_Mem_Addr  <= '0;
      o_Mem_WData <= '0;
      o_Cpu_Hold  <= 1'b0;
      o_Done      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      if (!tmo_active || i_Rx_DV) tmo_q <= '0;
      else if (tmo_q != '1)       tmo_q <= tmo_q + TMO_W'(1);

      if (clr_cnt) begin
        lane_q <= '0;
        addr_q <= '0;
`ifdef UART_LOADER_CSUM_EN
        csum_q <= '0;
`endif
      end

      if ((state_q == S_LEN_LO) && byte_ok) len_lo_q <= i_Rx_Byte;
      if (len_ld) rem_q <= n_words;

      if (byte_take) begin
        lane_q <= lane_q + 2'd1;
`ifdef UART_LOADER_CSUM_EN
        csum_q <= csum_q ^ i_Rx_Byte;
`endif
        case (lane_q)
          2'd0:    word_q[7:0]   <= i_Rx_Byte;
          2'd1:    word_q[15:8]  <= i_Rx_Byte;
          2'd2:    word_q[23:16] <= i_Rx_Byte;
          default: word_q        <= word_q;
        endcase
      end

      wr_pend_q <= word_done;
      if (word_done) begin
        wr_data_q <= {i_Rx_Byte, word_q};
        wr_addr_q <= addr_q[ADDR_WIDTH-1:0];
        addr_q    <= addr_q + CNT_W'(1);
        rem_q     <= rem_q - 16'd1;
      end

      o_Mem_WE <= wr_pend_q;
      if (wr_pend_q) begin
        o_Mem_Addr  <= wr_addr_q;
        o_Mem_WData <= wr_data_q;
      end

      o_Done     <= (state_q == S_DONE);
      o_Error    <= (state_q == S_ERROR);
      o_Cpu_Hold <= hold_c;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed frames plus random frames checked against a frame-level model.
module tb_uart_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 100;
  typedef logic [7:0] u8_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Mem_WE   (mem_we),
    .o_Mem_Addr (mem_addr),
    .o_Mem_WData(mem_wdata),
    .o_Cpu_Hold (cpu_hold),
    .o_Done     (done),
    .o_Error    (error)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write / done events, tagged with the cycle they were seen in.
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];
  int            dc[$];
  logic          dh[$];
  logic          dhp[$];
  logic          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      dc.push_back(cyc);
      dh.push_back(cpu_hold);
      dhp.push_back(prev_hold);
    end
    prev_hold <= cpu_hold;
  end

  u8_t  frm[$];
  int   bc[$];
  logic exp_err  = 1'b0;
  logic exp_hold = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); wc.delete();
    dc.delete(); dh.delete(); dhp.delete(); bc.delete();
  endtask

  // Called at a negedge; returns at a negedge. Records the cycle whose edge sampled the byte.
  task automatic send_byte(input u8_t b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1 bc.push_back(cyc);
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic build(input int n, input int ng);
    u8_t b;
    u8_t x;
    frm.delete();
    for (int i = 0; i < ng; i++) begin
      b = u8_t'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      frm.push_back(b);
    end
    frm.push_back(8'hA5);
    frm.push_back(u8_t'(n & 255));
    frm.push_back(u8_t'(n >> 8));
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = u8_t'($urandom_range(0, 255));
      x = x ^ b;
      frm.push_back(b);
    end
`ifdef UART_LOADER_CSUM_EN
    frm.push_back(x);
`endif
  endtask

  // Frame-level reference: locate sync, decode N, slice words, judge checksum.
  task automatic check_frame();
    int   i0;
    int   n;
    int   nw;
    int   base;
    int   last;
    bit   ok;
    u8_t  x;
    logic [31:0] w;
    i0 = -1;
    foreach (frm[i]) if (i0 < 0 && frm[i] == 8'hA5) i0 = i;
    if (i0 < 0) begin
      chk("idle_wr_count", 64'(wa.size()), 64'd0);
      chk("idle_done_count", 64'(dc.size()), 64'd0);
      chk("idle_hold", 64'(cpu_hold), 64'(exp_hold));
      chk("idle_error", 64'(error), 64'(exp_err));
      return;
    end
    n  = int'({frm[i0+2], frm[i0+1]});
    ok = (n >= 1) && (n <= (1 << AW));
    nw = ok ? n : 0;
    chk("wr_count", 64'(wa.size()), 64'(nw));
    x = 8'h00;
    for (int j = 0; j < nw; j++) begin
      base = i0 + 3 + 4 * j;
      w = {frm[base+3], frm[base+2], frm[base+1], frm[base]};
      x = x ^ frm[base] ^ frm[base+1] ^ frm[base+2] ^ frm[base+3];
      if (j < wa.size()) begin
        chk("wr_addr", 64'(wa[j]), 64'(j));
        chk("wr_data", 64'(wd[j]), 64'(w));
        chk("wr_latency", 64'(wc[j]), 64'(bc[base+3] + 1));
      end
    end
    last = i0 + 2 + 4 * n;
`ifdef UART_LOADER_CSUM_EN
    if (ok) begin
      last = last + 1;
      ok   = (frm[last] == x);
    end
`endif
    chk("done_count", 64'(dc.size()), ok ? 64'd1 : 64'd0);
    if (ok && dc.size() > 0) begin
      chk("done_cycle", 64'(dc[0]), 64'(bc[last] + 1));
      chk("hold_at_done", 64'(dh[0]), 64'd0);
      chk("hold_before_done", 64'(dhp[0]), 64'd1);
    end
    exp_err  = !ok;
    exp_hold = !ok;
    chk("frame_error", 64'(error), 64'(exp_err));
    chk("frame_hold", 64'(cpu_hold), 64'(exp_hold));
  endtask

  task automatic run_frame(input int gmax);
    clear_mon();
    foreach (frm[i]) send_byte(frm[i], $urandom_range(0, gmax));
    repeat (6) @(negedge clk);
    check_frame();
  endtask

  initial begin
    u8_t d[5];
    int  t_last;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word reference frame
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef UART_LOADER_CSUM_EN
    frm.push_back(8'h90);
`endif
    run_frame(1);
    if (wd.size() >= 2) begin
      chk("ref_word0", 64'(wd[0]), 64'h0000_0013);
      chk("ref_word1", 64'(wd[1]), 64'h0010_0093);
    end

    // Noise in IDLE, then a normal frame
    frm = '{8'h00, 8'hFF, 8'h3C};
    run_frame(1);
    build(3, 0);
    run_frame(2);

    // Length boundaries
    frm = '{8'hA5, 8'h00, 8'h00};
    run_frame(1);
    frm = '{8'hA5, 8'h01, 8'h01};
    run_frame(1);
    build(1 << AW, 0);
    run_frame(0);

`ifdef UART_LOADER_CSUM_EN
    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    run_frame(1);
    build(2, 0);
    run_frame(1);
`endif

    // Stall after 5 of 8 data bytes
    clear_mon();
    for (int i = 0; i < 5; i++) d[i] = u8_t'($urandom_range(0, 255));
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    for (int i = 0; i < 4; i++) send_byte(d[i], 1);
    send_byte(d[4], 0);
    t_last = bc[bc.size()-1];
    repeat (94) @(negedge clk);
    chk("tmo_cycle", 64'(cyc), 64'(t_last + 94));
    chk("tmo_early_error", 64'(error), 64'd0);
    repeat (11) @(negedge clk);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_hold", 64'(cpu_hold), 64'd1);
    chk("tmo_wr_count", 64'(wa.size()), 64'd1);
    if (wd.size() > 0) chk("tmo_word", 64'(wd[0]), 64'({d[3], d[2], d[1], d[0]}));
    exp_err  = 1'b1;
    exp_hold = 1'b1;
    build(2, 0);
    run_frame(1);

    // Random frames with leading noise and random byte spacing
    for (int k = 0; k < 8; k++) begin
      build($urandom_range(1, 6), $urandom_range(0, 2));
      run_frame(3);
    end

    // Reset in the cycle after a word's 4th byte
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    for (int i = 0; i < 3; i++) send_byte(u8_t'($urandom_range(0, 255)), 1);
    send_byte(u8_t'($urandom_range(0, 255)), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("squash_we", 64'(mem_we), 64'd0);
    chk("squash_addr", 64'(mem_addr), 64'd0);
    chk("squash_wdata", 64'(mem_wdata), 64'd0);
    chk("squash_hold", 64'(cpu_hold), 64'd0);
    chk("squash_done", 64'(done), 64'd0);
    chk("squash_error", 64'(error), 64'd0);
    repeat (5) @(negedge clk);
    chk("squash_wr_count", 64'(wa.size()), 64'd0);
    exp_err  = 1'b0;
    exp_hold = 1'b0;
    build(2, 1);
    run_frame(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
